// File: rtl/rsa_modmul_if.sv
// Start/busy/done handshake between the modular-exponentiation engine
// (master) and the rsa_modmul arithmetic stage (slave).
interface rsa_modmul_if #(
    parameter int WIDTH = 128
);
    logic               start;
    logic [2*WIDTH-1:0] a;
    logic [2*WIDTH-1:0] b;
    logic [2*WIDTH-1:0] n;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] result;
    logic               err;

    modport master (
        output start, a, b, n,
        input  busy, done, result, err
    );

    modport slave (
        input  start, a, b, n,
        output busy, done, result, err
    );
endinterface

// File: rtl/rsa_modmul.sv
// Interleaved (a*b) mod n, one bit of b per clock, MSB first.
// The accumulator stays below n after every step, so each step needs at
// most one conditional subtraction after the doubling and one after the add.
module rsa_modmul #(
    parameter int WIDTH = 128
) (
    input  logic         clk,
    input  logic         reset_n,
    rsa_modmul_if.slave  bus
);
    localparam int NW = 2 * WIDTH;
    localparam int IW = $clog2(NW);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state_q;
    logic [NW-1:0] a_q;
    logic [NW-1:0] b_q;       // shifted left each step; MSB is the current bit
    logic [NW-1:0] n_q;
    logic [NW-1:0] r_q;
    logic [NW-1:0] result_q;
    logic [IW-1:0] i_q;
    logic          bad_q;     // operands failed the range check at accept
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic          bad_d;
    logic [NW-1:0] r_d;
    logic [NW:0]   dbl;       // one extra bit so 2R never loses its carry
    logic [NW:0]   sum;       // one extra bit so R1 + a never loses its carry

    // One reduction step plus the operand range check on the live inputs.
    // NOTE: every combinational output is assigned before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        bad_d = (bus.n == '0) || (bus.a >= bus.n) || (bus.b >= bus.n);

        dbl = {r_q, 1'b0};
        if (dbl >= {1'b0, n_q}) begin
            dbl = dbl - {1'b0, n_q};
        end

        sum = {1'b0, dbl[NW-1:0]} + (b_q[NW-1] ? {1'b0, a_q} : '0);
        if (sum >= {1'b0, n_q}) begin
            sum = sum - {1'b0, n_q};
        end

        r_d = sum[NW-1:0];
    end

    // Control FSM, datapath registers and registered outputs.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            r_q      <= '0;
            result_q <= '0;
            i_q      <= '0;
            bad_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        n_q     <= bus.n;
                        bad_q   <= bad_d;
                        r_q     <= '0;
                        i_q     <= IW'(NW - 1);
                        err_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end

                RUN: begin
                    if (bad_q) begin
                        // Rejected operands: no bit is processed, the first
                        // cycle after accept goes straight to DONE.
                        result_q <= '0;
                        err_q    <= 1'b1;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        r_q <= r_d;
                        b_q <= b_q << 1;
                        i_q <= i_q - 1'b1;
                        if (i_q == '0) begin
                            result_q <= r_d;
                            done_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= DONE;
                        end
                    end
                end

                DONE: begin
                    // start is deliberately not sampled here.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_rsa_modmul.sv
// Directed bench for rsa_modmul: a WIDTH=4 and a WIDTH=128 instance share
// the operand drivers; sel picks which one a sequence talks to.
module tb_rsa_modmul;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         sel;
    logic         start4;
    logic         start128;
    logic [255:0] op_a;
    logic [255:0] op_b;
    logic [255:0] op_n;

    rsa_modmul_if #(.WIDTH(4))   if4 ();
    rsa_modmul_if #(.WIDTH(128)) if128 ();

    assign if4.start   = start4;
    assign if4.a       = op_a[7:0];
    assign if4.b       = op_b[7:0];
    assign if4.n       = op_n[7:0];
    assign if128.start = start128;
    assign if128.a     = op_a;
    assign if128.b     = op_b;
    assign if128.n     = op_n;

    rsa_modmul #(.WIDTH(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if4.slave)
    );

    rsa_modmul #(.WIDTH(128)) dut128 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if128.slave)
    );

    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic [255:0] o_result;

    // Output mux for whichever instance the current sequence targets.
    // NOTE: bench-side combinational logic also gets every output assigned
    // on every path.
    always_comb begin
        o_busy   = sel ? if128.busy   : if4.busy;
        o_done   = sel ? if128.done   : if4.done;
        o_err    = sel ? if128.err    : if4.err;
        o_result = sel ? if128.result : {248'b0, if4.result};
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start128 = v;
        else     start4   = v;
    endtask

    // One operation: accept, optional stray start at RUN cycle glitch_at,
    // then latency, result, err, done pulse width and result hold.
    task automatic run_op(input logic w128, input string tag,
                          input logic [255:0] a, input logic [255:0] b, input logic [255:0] n,
                          input logic [255:0] exp_res, input logic exp_err,
                          input int exp_lat, input int glitch_at);
        int   cyc;
        int   busy_drop;
        logic seen;
        sel = w128;
        @(negedge clk);
        op_a = a;
        op_b = b;
        op_n = n;
        set_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        check({tag, "_busy_acc"}, o_busy, 1'b1);
        cyc       = 0;
        busy_drop = 0;
        seen      = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (o_done) begin
                seen = 1'b1;
            end else begin
                if (!o_busy) busy_drop++;
                if (cyc == glitch_at) begin
                    op_a = 256'd10;
                    op_b = 256'd10;
                    op_n = 256'd11;
                    set_start(1'b1);
                end else begin
                    set_start(1'b0);
                end
            end
        end
        set_start(1'b0);
        check({tag, "_done_seen"}, seen, 1'b1);
        check({tag, "_busy_hold"}, busy_drop, 0);
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_result"}, o_result, exp_res);
        check({tag, "_err"}, o_err, exp_err);
        check({tag, "_busy_done"}, o_busy, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done_low"}, o_done, 1'b0);
        check({tag, "_result_held"}, o_result, exp_res);
        check({tag, "_err_held"}, o_err, exp_err);
    endtask

    logic [255:0] p_big;
    logic [255:0] q_big;
    logic [255:0] n_big;

    int           acc_t  [4];
    int           done_t [4];
    logic [255:0] res_t  [4];
    logic [255:0] exp_b2b[3];

    initial begin
        int   nacc;
        int   ndone;
        int   cyc;
        logic prev_busy;

        p_big = 256'd113680897410347;
        q_big = 256'd7999808077935876437321;
        n_big = p_big * q_big;

        reset_n  = 1'b0;
        sel      = 1'b0;
        start4   = 1'b0;
        start128 = 1'b0;
        op_a     = '0;
        op_b     = '0;
        op_n     = '0;
        repeat (2) @(negedge clk);
        check("rst4_busy",    if4.busy,     1'b0);
        check("rst4_done",    if4.done,     1'b0);
        check("rst4_err",     if4.err,      1'b0);
        check("rst4_result",  if4.result,   8'd0);
        check("rst128_busy",  if128.busy,   1'b0);
        check("rst128_result", if128.result, 256'd0);
        reset_n = 1'b1;

        // WIDTH=4 arithmetic vectors: 200*150=30000=119*251+131, etc.
        run_op(1'b0, "w4_200x150", 256'd200, 256'd150, 256'd251, 256'd131, 1'b0, 8, -1);
        run_op(1'b0, "w4_10x10",   256'd10,  256'd10,  256'd11,  256'd1,   1'b0, 8, -1);
        run_op(1'b0, "w4_254sq",   256'd254, 256'd254, 256'd255, 256'd1,   1'b0, 8, -1);
        run_op(1'b0, "w4_a0",      256'd0,   256'd7,   256'd9,   256'd0,   1'b0, 8, -1);
        run_op(1'b0, "w4_7x8",     256'd7,   256'd8,   256'd9,   256'd2,   1'b0, 8, -1);

        // Operand violations: one-cycle error path.
        run_op(1'b0, "w4_a_ge_n",  256'd12,  256'd3,   256'd11,  256'd0,   1'b1, 1, -1);
        run_op(1'b0, "w4_n0",      256'd5,   256'd3,   256'd0,   256'd0,   1'b1, 1, -1);
        run_op(1'b0, "w4_b_eq_n",  256'd1,   256'd11,  256'd11,  256'd0,   1'b1, 1, -1);

        // Stray start at RUN cycle 3 with other operands must be ignored.
        run_op(1'b0, "w4_glitch",  256'd200, 256'd150, 256'd251, 256'd131, 1'b0, 8, 3);

        // Reset at RUN cycle 5 aborts and clears every output at once.
        sel = 1'b0;
        @(negedge clk);
        op_a   = 256'd7;
        op_b   = 256'd8;
        op_n   = 256'd9;
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("abort_busy",   o_busy,   1'b0);
        check("abort_done",   o_done,   1'b0);
        check("abort_result", o_result, 256'd0);
        check("abort_err",    o_err,    1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("abort_no_done", o_done, 1'b0);
        run_op(1'b0, "w4_post_rst", 256'd10, 256'd10, 256'd11, 256'd1, 1'b0, 8, -1);

        // start held high across three operations.
        exp_b2b[0] = 256'd131;
        exp_b2b[1] = 256'd2;
        exp_b2b[2] = 256'd1;
        sel       = 1'b0;
        @(negedge clk);
        op_a      = 256'd200;
        op_b      = 256'd150;
        op_n      = 256'd251;
        start4    = 1'b1;
        nacc      = 0;
        ndone     = 0;
        cyc       = 0;
        prev_busy = o_busy;
        repeat (40) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (o_busy && !prev_busy && nacc < 4) begin
                acc_t[nacc] = cyc;
                nacc++;
                if (nacc == 1) begin
                    op_a = 256'd7;   op_b = 256'd8;   op_n = 256'd9;
                end else if (nacc == 2) begin
                    op_a = 256'd254; op_b = 256'd254; op_n = 256'd255;
                end else begin
                    start4 = 1'b0;
                end
            end
            if (o_done && ndone < 4) begin
                done_t[ndone] = cyc;
                res_t[ndone]  = o_result;
                ndone++;
            end
            prev_busy = o_busy;
        end
        start4 = 1'b0;
        check("b2b_accepts", nacc, 3);
        check("b2b_dones",   ndone, 3);
        if (nacc == 3 && ndone == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_lat%0d", i), done_t[i] - acc_t[i], 8);
                check($sformatf("b2b_res%0d", i), res_t[i], exp_b2b[i]);
            end
            check("b2b_space01", acc_t[1] - acc_t[0], 10);
            check("b2b_space12", acc_t[2] - acc_t[1], 10);
        end

        // WIDTH=128 vectors over n = 113680897410347 * 7999808077935876437321.
        run_op(1'b1, "w128_nm1sq", n_big - 1, n_big - 1, n_big, 256'd1,     1'b0, 256, -1);
        run_op(1'b1, "w128_a0",    256'd0,    n_big - 1, n_big, 256'd0,     1'b0, 256, -1);
        run_op(1'b1, "w128_b1",    n_big - 2, 256'd1,    n_big, n_big - 2,  1'b0, 256, -1);
        run_op(1'b1, "w128_small", 256'd12345, 256'd67890, n_big, 256'd838102050, 1'b0, 256, -1);
        run_op(1'b1, "w128_x2",    n_big - 1, 256'd2,    n_big, n_big - 2,  1'b0, 256, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
